// File: rtl/skewed_mac.sv
// skewed_mac: bit-skewed multiply-accumulate, acc_n = (clr_n ? 0 : acc_{n-1}) + in1_n * in2_n.
// Bit k of sample n is on in1_i/in2_i at cycle n+k; acc_o bit k of sample n is valid at n+k+2.
// clr_i is unskewed and presented with bit 0 of its sample.
// Defining SKEWED_MAC_OVF_EN adds a sticky overflow output ovf_o, aligned with the acc MSB.
module skewed_mac #(
  parameter int unsigned WIDTH1    = 3,
  parameter int unsigned WIDTH2    = 3,
  parameter int unsigned ACC_WIDTH = 10,
  parameter bit          SIGNED    = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 clr_i,
  input  logic [WIDTH1-1:0]    in1_i,
  input  logic [WIDTH2-1:0]    in2_i,
`ifdef SKEWED_MAC_OVF_EN
  output logic                 ovf_o,
`endif
  output logic [ACC_WIDTH-1:0] acc_o
);

  localparam int unsigned PW = WIDTH1 + WIDTH2;

  if (ACC_WIDTH < PW) begin : g_width_check
    $fatal(1, "skewed_mac: ACC_WIDTH must be >= WIDTH1 + WIDTH2");
  end

  // a1_q[k] holds bits 0..k of the operand whose bit k+1 arrives next cycle (triangular deskew).
  logic [WIDTH1-1:0]    a1_q    [PW-1];
  logic [WIDTH2-1:0]    a2_q    [PW-1];
  logic [WIDTH1-1:0]    part1   [PW];
  logic [WIDTH2-1:0]    part2   [PW];
  logic [PW-1:0]        ext1, ext2, full;
  logic [ACC_WIDTH-1:0] prod_d, prod_q;
  logic [ACC_WIDTH-1:0] sum_d, sum_q;
  logic [ACC_WIDTH-1:0] base, carry_in;
  logic [ACC_WIDTH-2:0] carry_d, carry_q;
  // clr_q[k] is clr_i delayed k+1 cycles, i.e. the clear seen by accumulator lane k.
  logic [ACC_WIDTH-1:0] clr_q;

  // Multiply stage: lane k forms product bit k from the operand bits 0..k known so far.
  always_comb begin
    part1  = '{default: '0};
    part2  = '{default: '0};
    ext1   = '0;
    ext2   = '0;
    full   = '0;
    prod_d = '0;
    part1[0] = in1_i & WIDTH1'(1);
    part2[0] = in2_i & WIDTH2'(1);
    for (int k = 1; k < PW; k++) begin
      part1[k] = a1_q[k-1] | (in1_i & (WIDTH1'(1) << k));
      part2[k] = a2_q[k-1] | (in2_i & (WIDTH2'(1) << k));
    end
    // Product bit k only depends on operand bits 0..k, so partial operands are enough.
    for (int k = 0; k < PW; k++) begin
      ext1      = {{WIDTH2{SIGNED & part1[k][WIDTH1-1]}}, part1[k]};
      ext2      = {{WIDTH1{SIGNED & part2[k][WIDTH2-1]}}, part2[k]};
      full      = ext1 * ext2;
      prod_d[k] = full[k];
    end
    // Upper lanes: product MSB passed one lane per cycle (sign extension), or zero.
    for (int k = PW; k < ACC_WIDTH; k++) begin
      prod_d[k] = SIGNED & prod_q[k-1];
    end
  end

  // Accumulate stage: one full adder per lane, carry handed to the next lane a cycle later.
  always_comb begin
    base     = sum_q & ~clr_q;
    carry_in = {carry_q, 1'b0};
    sum_d    = prod_q ^ base ^ carry_in;
    carry_d  = (prod_q[ACC_WIDTH-2:0] & base[ACC_WIDTH-2:0])
             | (prod_q[ACC_WIDTH-2:0] & carry_in[ACC_WIDTH-2:0])
             | (base[ACC_WIDTH-2:0]   & carry_in[ACC_WIDTH-2:0]);
  end

  // Pipeline state; en_i low freezes every register including the skew chains.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < PW - 1; k++) begin
        a1_q[k] <= '0;
        a2_q[k] <= '0;
      end
      prod_q  <= '0;
      sum_q   <= '0;
      carry_q <= '0;
      clr_q   <= '0;
    end else if (en_i) begin
      for (int k = 0; k < PW - 1; k++) begin
        a1_q[k] <= part1[k];
        a2_q[k] <= part2[k];
      end
      prod_q  <= prod_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      clr_q   <= {clr_q[ACC_WIDTH-2:0], clr_i};
    end
  end

  assign acc_o = sum_q;

`ifdef SKEWED_MAC_OVF_EN
  logic ovf_d, ovf_q, msb_cout;

  // Sticky overflow of the MSB lane; a clear restarts it from this sample alone.
  always_comb begin
    msb_cout = (prod_q[ACC_WIDTH-1] & base[ACC_WIDTH-1])
             | (prod_q[ACC_WIDTH-1] & carry_in[ACC_WIDTH-1])
             | (base[ACC_WIDTH-1]   & carry_in[ACC_WIDTH-1]);
    ovf_d    = (clr_q[ACC_WIDTH-1] ? 1'b0 : ovf_q)
             | (SIGNED ? (carry_in[ACC_WIDTH-1] ^ msb_cout) : msb_cout);
  end

  // Overflow flag register, updated in step with the MSB sum lane.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= 1'b0;
    end else if (en_i) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_o = ovf_q;
`endif

endmodule

// File: tb/tb_skewed_mac.sv
// tb_skewed_mac: four skewed_mac variants (ACC 10/6, unsigned/signed) driven by one skewed bus.
// Expected results come from an arithmetic model of aligned samples plus hand-derived tables.
`timescale 1ns/1ps
module tb_skewed_mac;

  localparam int NI = 4;
  localparam int NS = 4096;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic [2:0] in1 = '0;
  logic [2:0] in2 = '0;
  logic [9:0] acc0, acc2;
  logic [5:0] acc1, acc3;
`ifdef SKEWED_MAC_OVF_EN
  logic       ovf0, ovf1, ovf2, ovf3;
`endif

  always #5 clk = ~clk;

  skewed_mac #(.WIDTH1(3), .WIDTH2(3), .ACC_WIDTH(10), .SIGNED(1'b0)) u_u10 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clr_i(clr), .in1_i(in1), .in2_i(in2),
`ifdef SKEWED_MAC_OVF_EN
    .ovf_o(ovf0),
`endif
    .acc_o(acc0));
  skewed_mac #(.WIDTH1(3), .WIDTH2(3), .ACC_WIDTH(6), .SIGNED(1'b0)) u_u6 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clr_i(clr), .in1_i(in1), .in2_i(in2),
`ifdef SKEWED_MAC_OVF_EN
    .ovf_o(ovf1),
`endif
    .acc_o(acc1));
  skewed_mac #(.WIDTH1(3), .WIDTH2(3), .ACC_WIDTH(10), .SIGNED(1'b1)) u_s10 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clr_i(clr), .in1_i(in1), .in2_i(in2),
`ifdef SKEWED_MAC_OVF_EN
    .ovf_o(ovf2),
`endif
    .acc_o(acc2));
  skewed_mac #(.WIDTH1(3), .WIDTH2(3), .ACC_WIDTH(6), .SIGNED(1'b1)) u_s6 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clr_i(clr), .in1_i(in1), .in2_i(in2),
`ifdef SKEWED_MAC_OVF_EN
    .ovf_o(ovf3),
`endif
    .acc_o(acc3));

  // Aligned-sample model state; e counts enabled cycles since reset release.
  int          e;
  int unsigned sa [NS];
  int unsigned sb [NS];
  bit          sc [NS];
  longint      g_acc [NI][NS];
  bit          g_ovf [NI][NS];
  logic [9:0]  cap [NI][NS];
  logic        cap_ovf [NI][NS];
  int          checks = 0;
  int          errors = 0;

  typedef struct packed {
    bit         rst;
    logic [2:0] a;
    logic [2:0] b;
    bit         c;
    logic [9:0] e0;
    logic [9:0] e1;
    logic [9:0] e2;
    logic [9:0] e3;
    bit         o1;
  } vec_t;
  vec_t tbl [12];

  function automatic int aw(input int i);
    return (i % 2 == 0) ? 10 : 6;
  endfunction

  function automatic bit sg(input int i);
    return i >= 2;
  endfunction

  function automatic longint sext(input longint v, input int w, input bit s);
    longint one;
    one = 1;
    if (s && v[w-1]) return v - (one << w);
    return v;
  endfunction

  function automatic logic [9:0] dut_acc(input int i);
    case (i)
      0:       return acc0;
      1:       return {4'b0, acc1};
      2:       return acc2;
      default: return {4'b0, acc3};
    endcase
  endfunction

`ifdef SKEWED_MAC_OVF_EN
  function automatic logic dut_ovf(input int i);
    case (i)
      0:       return ovf0;
      1:       return ovf1;
      2:       return ovf2;
      default: return ovf3;
    endcase
  endfunction
`endif

  // Record sample e and compute its golden accumulator value for every variant.
  task automatic push(input int unsigned a, input int unsigned b, input bit c);
    longint m, prev, p, s;
    bit     prev_ovf, ov;
    sa[e] = a;
    sb[e] = b;
    sc[e] = c;
    for (int i = 0; i < NI; i++) begin
      m        = longint'(1) << aw(i);
      prev     = (e == 0 || c) ? 0 : g_acc[i][e-1];
      prev_ovf = (e == 0 || c) ? 1'b0 : g_ovf[i][e-1];
      p        = sext(longint'(a), 3, sg(i)) * sext(longint'(b), 3, sg(i));
      if (sg(i)) begin
        s  = sext(prev, aw(i), 1'b1) + p;
        ov = (s < -(m / 2)) || (s >= m / 2);
      end else begin
        s  = prev + p;
        ov = (s >= m);
      end
      g_acc[i][e] = ((s % m) + m) % m;
      g_ovf[i][e] = prev_ovf | ov;
    end
  endtask

  // Compare each output bit with the model sample it belongs to; also capture aligned words.
  task automatic check_cycle();
    logic [9:0] exp, act;
    int         n;
    for (int i = 0; i < NI; i++) begin
      exp = '0;
      act = dut_acc(i);
      for (int k = 0; k < aw(i); k++) begin
        n = e - k - 2;
        if (n >= 0) begin
          exp[k]       = g_acc[i][n][k];
          cap[i][n][k] = act[k];
        end
      end
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL model_acc inst%0d e=%0d: got %h expected %h", i, e, act, exp);
      end
`ifdef SKEWED_MAC_OVF_EN
      n = e - aw(i) - 1;
      checks++;
      if (dut_ovf(i) !== ((n >= 0) ? g_ovf[i][n] : 1'b0)) begin
        errors++;
        $display("FAIL model_ovf inst%0d e=%0d: got %b expected %b", i, e, dut_ovf(i),
                 (n >= 0) ? g_ovf[i][n] : 1'b0);
      end
      if (n >= 0) cap_ovf[i][n] = dut_ovf(i);
`endif
    end
  endtask

  // One clock: check outputs, then drive the skewed bus (bit k carries sample e-k).
  task automatic cycle(input bit en_v, input int unsigned a, input int unsigned b, input bit c);
    int n;
    @(negedge clk);
    check_cycle();
    en = en_v;
    if (en_v) begin
      push(a, b, c);
      for (int k = 0; k < 3; k++) begin
        n      = e - k;
        in1[k] = (n >= 0) ? sa[n][k] : 1'b0;
        in2[k] = (n >= 0) ? sb[n][k] : 1'b0;
      end
      clr = c;
    end else begin
      // Bus contents are don't-care while stalled.
      in1 = 3'($urandom);
      in2 = 3'($urandom);
      clr = 1'($urandom);
    end
    @(posedge clk);
    if (en_v) e++;
  endtask

  task automatic flush();
    repeat (12) cycle(1'b1, 0, 0, 1'b0);
  endtask

  // Reset with en and clr high: reset must win.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en    = 1'b1;
    clr   = 1'b1;
    in1   = 3'b111;
    in2   = 3'b111;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (dut_acc(i) !== 10'd0) begin
        errors++;
        $display("FAIL reset_acc inst%0d: got %h expected 0", i, dut_acc(i));
      end
    end
    rst_n = 1'b1;
    en    = 1'b0;
    e     = 0;
  endtask

  task automatic cmp_cap(input int i, input int n, input logic [9:0] want, input string name);
    checks++;
    if (cap[i][n] !== want) begin
      errors++;
      $display("FAIL %s inst%0d sample%0d: got %0d expected %0d", name, i, n, cap[i][n], want);
    end
  endtask

  task automatic check_group(input int s, input int n_end);
    for (int j = s; j < n_end; j++) begin
      cmp_cap(0, j - s, tbl[j].e0, "table");
      cmp_cap(1, j - s, tbl[j].e1, "table");
      cmp_cap(2, j - s, tbl[j].e2, "table");
      cmp_cap(3, j - s, tbl[j].e3, "table");
`ifdef SKEWED_MAC_OVF_EN
      checks++;
      if (cap_ovf[1][j-s] !== tbl[j].o1) begin
        errors++;
        $display("FAIL table_ovf sample%0d: got %b expected %b", j - s, cap_ovf[1][j-s], tbl[j].o1);
      end
`endif
    end
  endtask

  initial begin
    int start;
    // rst, a, b, clr, acc(u10), acc(u6), acc(s10), acc(s6), ovf(u6)
    tbl[0]  = '{1'b1, 3'd7, 3'd7, 1'b1, 10'd49,  10'd49, 10'd1,    10'd1,  1'b0};
    tbl[1]  = '{1'b0, 3'd7, 3'd7, 1'b0, 10'd98,  10'd34, 10'd2,    10'd2,  1'b1};
    tbl[2]  = '{1'b0, 3'd7, 3'd7, 1'b0, 10'd147, 10'd19, 10'd3,    10'd3,  1'b1};
    tbl[3]  = '{1'b0, 3'd7, 3'd7, 1'b0, 10'd196, 10'd4,  10'd4,    10'd4,  1'b1};
    tbl[4]  = '{1'b1, 3'd7, 3'd7, 1'b1, 10'd49,  10'd49, 10'd1,    10'd1,  1'b0};
    tbl[5]  = '{1'b0, 3'd7, 3'd7, 1'b0, 10'd98,  10'd34, 10'd2,    10'd2,  1'b1};
    tbl[6]  = '{1'b0, 3'd1, 3'd1, 1'b1, 10'd1,   10'd1,  10'd1,    10'd1,  1'b0};
    tbl[7]  = '{1'b1, 3'd7, 3'd3, 1'b1, 10'd21,  10'd21, 10'h3FD,  10'd61, 1'b0};
    tbl[8]  = '{1'b0, 3'd4, 3'd4, 1'b0, 10'd37,  10'd37, 10'd13,   10'd13, 1'b0};
    tbl[9]  = '{1'b1, 3'd5, 3'd6, 1'b1, 10'd30,  10'd30, 10'd6,    10'd6,  1'b0};
    tbl[10] = '{1'b0, 3'd3, 3'd2, 1'b1, 10'd6,   10'd6,  10'd6,    10'd6,  1'b0};
    tbl[11] = '{1'b0, 3'd2, 3'd2, 1'b1, 10'd4,   10'd4,  10'd4,    10'd4,  1'b0};
    e = 0;

    start = 0;
    for (int j = 0; j < 12; j++) begin
      if (tbl[j].rst) begin
        if (j > 0) begin
          flush();
          check_group(start, j);
        end
        do_reset();
        start = j;
      end
      cycle(1'b1, tbl[j].a, tbl[j].b, tbl[j].c);
    end
    flush();
    check_group(start, 12);

    // Stall with bits of the first sample still in flight.
    do_reset();
    cycle(1'b1, 2, 3, 1'b1);
    repeat (3) cycle(1'b0, 0, 0, 1'b0);
    cycle(1'b1, 1, 5, 1'b0);
    flush();
    cmp_cap(0, 0, 10'd6, "stall");
    cmp_cap(0, 1, 10'd11, "stall");
    cmp_cap(2, 1, 10'd3, "stall");

    // Asynchronous reset mid-run, then accumulate onto zero without clr.
    do_reset();
    cycle(1'b1, 7, 7, 1'b1);
    cycle(1'b1, 7, 7, 1'b0);
    cycle(1'b1, 0, 0, 1'b0);
    cycle(1'b1, 0, 0, 1'b0);
    @(negedge clk);
    check_cycle();
    en = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (dut_acc(i) !== 10'd0) begin
        errors++;
        $display("FAIL async_reset inst%0d: got %h expected 0", i, dut_acc(i));
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b0;
    e     = 0;
    cycle(1'b1, 2, 2, 1'b0);
    flush();
    cmp_cap(0, 0, 10'd4, "post_reset");
    cmp_cap(1, 0, 10'd4, "post_reset");
    cmp_cap(2, 0, 10'd4, "post_reset");
    cmp_cap(3, 0, 10'd4, "post_reset");

    // Random regression against the model.
    do_reset();
    repeat (2000) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 4) == 0);
    end
    flush();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
